bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that produces the ones/tens/hundreds digits consumed by the LED digit-select mux.
- Sits between the switch input and the digit mux.
- Takes an unsigned binary value on a start pulse and iterates one bit per clock.
- Holds the three BCD digits stable until the next conversion completes.

---
 rtl/bin_to_bcd_seq_pkg.sv | 19 +
 rtl/bin_to_bcd_seq_add3.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq shared types and constants.
// Sequential double-dabble binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam int BCD_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = BCD_DIGITS * DIGIT_W;

  // Scratch register: BCD digit fields above the binary operand.
  function automatic int scratch_w(input int width);
    return width + BCD_W;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3: double-dabble digit correction.
// Adds 3 to a BCD digit field holding 5..9 so the next shift carries out.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Correct fields that would reach 10+ after doubling.
  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(5)) dout = din + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock binary to 3-digit BCD.
// Digits hold their last result until the next conversion completes.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hundos
);

  localparam int SW = scratch_w(WIDTH);

  state_e             state_q, state_d;
  logic [SW-1:0]      scr_q, scr_d;
  logic [SW-1:0]      fix, shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] hund_q, hund_d;
  logic [DIGIT_W-1:0] add_out [BCD_DIGITS];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr_q[WIDTH+g*DIGIT_W +: DIGIT_W]),
      .dout (add_out[g])
    );
  end

  // Replace digit fields with corrected values, then shift left one.
  always_comb begin
    fix = scr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      fix[WIDTH+i*DIGIT_W +: DIGIT_W] = add_out[i];
    end
    shifted = fix << 1;
  end

  // Next-state and datapath updates for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          scr_d   = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          ones_d  = shifted[WIDTH             +: DIGIT_W];
          tens_d  = shifted[WIDTH+DIGIT_W     +: DIGIT_W];
          hund_d  = shifted[WIDTH+2*DIGIT_W   +: DIGIT_W];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign ones   = ones_q;
  assign tens   = tens_q;
  assign hundos = hund_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks for bin_to_bcd_seq.
// Outputs are sampled 1ns after each rising edge.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bin = '0;
  logic       busy, done;
  logic [3:0] ones, tens, hundos;

  int errs = 0;
  int checks = 0;

  bin_to_bcd_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .ones   (ones),
    .tens   (tens),
    .hundos (hundos)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with v, then run until done (bounded).
  // lat: edges after the accepting edge until done is seen.
  // bc: cycles with busy high; chg: digits moved before done.
  task automatic run_conv(input logic [7:0] v, output int lat,
                          output int bc, output bit chg);
    logic [11:0] prev;
    prev  = {hundos, tens, ones};
    start = 1'b1;
    bin   = v;
    step();
    start = 1'b0;
    lat = 0;
    bc  = 0;
    chg = 1'b0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if ({hundos, tens, ones} !== prev) chg = 1'b1;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({busy, done, hundos, tens, ones} !== 14'd0) begin
      errs++;
      $display("FAIL reset_state got %b/%b %0d%0d%0d want 0/0 000",
               busy, done, hundos, tens, ones);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if ({busy, done, hundos, tens, ones} !== 14'd0) begin
      errs++;
      $display("FAIL idle_hold got %b/%b %0d%0d%0d want 0/0 000",
               busy, done, hundos, tens, ones);
    end
  endtask

  task automatic test_max();
    int lat, bc;
    bit chg;
    run_conv(8'd255, lat, bc, chg);
    checks++;
    if (lat != 8 || bc != 8 || busy !== 1'b0) begin
      errs++;
      $display("FAIL max_timing got lat=%0d busy_cyc=%0d busy=%b want 8 8 0",
               lat, bc, busy);
    end
    checks++;
    if ({hundos, tens, ones} !== 12'h255) begin
      errs++;
      $display("FAIL max_digits got %0d%0d%0d want 255",
               hundos, tens, ones);
    end
    checks++;
    if (chg) begin
      errs++;
      $display("FAIL max_no_interm got changed=1 want 0");
    end
    step();
    checks++;
    if (done !== 1'b0 || {hundos, tens, ones} !== 12'h255) begin
      errs++;
      $display("FAIL max_pulse got done=%b %0d%0d%0d want 0 255",
               done, hundos, tens, ones);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit chg;
    run_conv(8'd0, lat, bc, chg);
    checks++;
    if (lat != 8 || {hundos, tens, ones} !== 12'h000) begin
      errs++;
      $display("FAIL b2b_zero got lat=%0d %0d%0d%0d want 8 000",
               lat, hundos, tens, ones);
    end
    run_conv(8'd128, lat, bc, chg);
    checks++;
    if (lat != 8 || bc != 8 || {hundos, tens, ones} !== 12'h128) begin
      errs++;
      $display("FAIL b2b_128 got lat=%0d busy_cyc=%0d %0d%0d%0d want 8 8 128",
               lat, bc, hundos, tens, ones);
    end
    step();
  endtask

  task automatic test_ignored_start();
    int s, extra;
    start = 1'b1;
    bin   = 8'd99;
    step();
    start = 1'b0;
    s = 0;
    while (!done && s < 20) begin
      if (s == 3) begin
        start = 1'b1;
        bin   = 8'd200;
      end else begin
        start = 1'b0;
      end
      step();
      s++;
    end
    start = 1'b0;
    bin   = 8'd0;
    checks++;
    if (s != 8 || {hundos, tens, ones} !== 12'h099) begin
      errs++;
      $display("FAIL ign_start got lat=%0d %0d%0d%0d want 8 099",
               s, hundos, tens, ones);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy || done) extra++;
    end
    checks++;
    if (extra != 0 || {hundos, tens, ones} !== 12'h099) begin
      errs++;
      $display("FAIL ign_no_second got active=%0d %0d%0d%0d want 0 099",
               extra, hundos, tens, ones);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dn;
    bit chg;
    run_conv(8'd42, lat, bc, chg);
    checks++;
    if ({hundos, tens, ones} !== 12'h042) begin
      errs++;
      $display("FAIL rst_mid_prior got %0d%0d%0d want 042",
               hundos, tens, ones);
    end
    step();
    start = 1'b1;
    bin   = 8'd173;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({busy, done, hundos, tens, ones} !== 14'd0) begin
      errs++;
      $display("FAIL rst_mid_clear got %b/%b %0d%0d%0d want 0/0 000",
               busy, done, hundos, tens, ones);
    end
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) dn++;
    end
    checks++;
    if (dn != 0) begin
      errs++;
      $display("FAIL rst_mid_nodone got active=%0d want 0", dn);
    end
    run_conv(8'd173, lat, bc, chg);
    checks++;
    if (lat != 8 || {hundos, tens, ones} !== 12'h173) begin
      errs++;
      $display("FAIL rst_mid_redo got lat=%0d %0d%0d%0d want 8 173",
               lat, hundos, tens, ones);
    end
  endtask

  task automatic test_sweep();
    int lat, bc;
    bit chg;
    logic [3:0] eh, et, eo;
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), lat, bc, chg);
      eh = 4'(v / 100);
      et = 4'((v / 10) % 10);
      eo = 4'(v % 10);
      checks++;
      if ({hundos, tens, ones} !== {eh, et, eo}) begin
        errs++;
        $display("FAIL sweep_digits v=%0d got %0d%0d%0d want %0d%0d%0d",
                 v, hundos, tens, ones, eh, et, eo);
      end
      checks++;
      if (lat != 8 || bc != 8 || chg ||
          hundos > 4'd9 || tens > 4'd9 || ones > 4'd9) begin
        errs++;
        $display("FAIL sweep_timing v=%0d got lat=%0d busy_cyc=%0d chg=%0d want 8 8 0",
                 v, lat, bc, chg);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
